conv_window_buf: RTL

//  Parametrised sliding-window generator feeding the conv layers of the MNIST datapath.

---
 rtl/conv_window_buf.sv | 138 +++++++++++++
 1 files changed

// File: rtl/conv_window_buf.sv
// conv_window_buf: sliding KxK window generator over a raster-order pixel stream.
// Windows are emitted over the valid region only (no padding) at a configurable
// stride. Both sides use a valid/ready handshake, and storage advances only when
// a pixel is accepted.
module conv_window_buf #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [K*K*DATA_W-1:0] out_window,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int PH_W   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int LAST_R = K - 1 + ((IMG_H - K) / STRIDE) * STRIDE;
  localparam int LAST_C = K - 1 + ((IMG_W - K) / STRIDE) * STRIDE;

  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LAST_C);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(LAST_R);
  localparam logic [PH_W-1:0]  PH_MAX    = PH_W'(STRIDE - 1);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  // Stride phase of the current column/row within the valid region; 0 = aligned.
  logic [PH_W-1:0]   col_ph;
  logic [PH_W-1:0]   row_ph;

  // line_buf[0] holds the oldest row (row-(K-1)), line_buf[K-2] the previous row.
  logic [DATA_W-1:0] line_buf [K-1][IMG_W];
  logic [DATA_W-1:0] win      [K][K];
  logic [DATA_W-1:0] col_vec  [K];

  logic accept;
  logic emit;
  logic is_last;
  logic col_wrap;

  // NOTE: in_ready depends combinationally on out_ready so a consumed window frees
  // the pipeline in the same cycle; the downstream must not loop out_ready on in_ready.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_wrap = (col == COL_MAX);
  assign is_last  = (row == ROW_LAST) && (col == COL_LAST);
  assign emit     = (row >= ROW_FIRST) && (col >= COL_FIRST) &&
                    (row_ph == '0) && (col_ph == '0);

  // Vertical slice entering the window: buffered rows on top, the new pixel at the bottom.
  always_comb begin
    for (int r = 0; r < K; r++) col_vec[r] = '0;
    for (int r = 0; r < K - 1; r++) col_vec[r] = line_buf[r][col];
    col_vec[K-1] = in_data;
  end

  // Raster position and stride phase of the pixel being accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      col_ph <= '0;
      row_ph <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col    <= '0;
        col_ph <= '0;
        if (row == ROW_MAX) begin
          row    <= '0;
          row_ph <= '0;
        end else begin
          row <= row + 1'b1;
          if (row >= ROW_FIRST) row_ph <= (row_ph == PH_MAX) ? '0 : row_ph + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        if (col >= COL_FIRST) col_ph <= (col_ph == PH_MAX) ? '0 : col_ph + 1'b1;
      end
    end
  end

  // Line buffers: each column entry shifts up one row on accept.
  // NOTE: no reset on the RAM; every entry is rewritten before it can reach an
  // emitted window, and leaving it out lets the array map onto plain memory.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < K - 1; j++) line_buf[j][col] <= col_vec[j+1];
    end
  end

  // Window shift register: columns move left, the new slice enters at c = K-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= col_vec[r];
      end
    end
  end

  // Output qualifiers: load on accept, clear when consumed, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= emit;
      out_last  <= emit && is_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // Flatten the window: slot r*K+c at bits [(r*K+c)*DATA_W +: DATA_W].
  always_comb begin
    out_window = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        out_window[(r*K+c)*DATA_W +: DATA_W] = win[r][c];
  end

endmodule
